// File: rtl/uart_event_queue_if.sv
// Event-in / byte-out handshake bundle for uart_event_queue.
// The slave side is the queue; the master side is the producer plus uart_tx.
`timescale 1ns/1ps
interface uart_event_queue_if;
    logic       event_valid;
    logic [7:0] event_data;
    logic       sync_req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output event_valid, event_data, sync_req, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  event_valid, event_data, sync_req, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/uart_event_queue.sv
// Queues sequencer event bytes and sync requests, then serialises them as a
// valid/ready byte stream with sync markers and byte-stuffed event data.
`timescale 1ns/1ps
module uart_event_queue #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hFF,
    parameter logic [7:0] ESC_BYTE  = 8'hFE,
    parameter logic [7:0] ESC_XOR   = 8'h20
) (
    input  logic                     clk,
    input  logic                     rstn,
    uart_event_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               overflow_count,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        SEND_ESC = 2'd2
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [LW-1:0] level_next;
    logic [7:0]    overflow_reg;
    logic          sync_pending_reg;

    state_t        state_reg;
    logic [7:0]    tx_data_reg;
    logic          tx_valid_reg;
    logic [7:0]    esc_second_reg;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          drop;
    logic          pop;
    logic          load_sync;
    logic [7:0]    head;
    logic          head_is_special;

    // Fullness is judged on the registered level, so a push that coincides
    // with a pop while full is still dropped.
    assign fifo_full       = (level_reg == LW'(DEPTH));
    assign fifo_empty      = (level_reg == '0);
    assign push            = bus.event_valid && !fifo_full;
    assign drop            = bus.event_valid && fifo_full;
    assign load_sync       = (state_reg == IDLE) && sync_pending_reg;
    assign pop             = (state_reg == IDLE) && !sync_pending_reg && !fifo_empty;
    assign head            = mem[rd_ptr_reg];
    assign head_is_special = (head == SYNC_BYTE) || (head == ESC_BYTE);

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    // Storage carries no reset; the pointers alone define what is queued.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.event_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            level_reg        <= '0;
            overflow_reg     <= '0;
            sync_pending_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_next;
            if (drop && (overflow_reg != 8'hFF)) begin
                overflow_reg <= overflow_reg + 8'd1;
            end
            // A request landing on the load edge coalesces into the marker being loaded.
            if (load_sync) begin
                sync_pending_reg <= 1'b0;
            end else if (bus.sync_req) begin
                sync_pending_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            tx_data_reg    <= '0;
            tx_valid_reg   <= 1'b0;
            esc_second_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sync_pending_reg) begin
                        tx_data_reg  <= SYNC_BYTE;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= SEND;
                    end else if (!fifo_empty) begin
                        tx_valid_reg <= 1'b1;
                        if (head_is_special) begin
                            tx_data_reg    <= ESC_BYTE;
                            esc_second_reg <= head ^ ESC_XOR;
                            state_reg      <= SEND_ESC;
                        end else begin
                            tx_data_reg <= head;
                            state_reg   <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                SEND_ESC: begin
                    // The second half of a pair follows directly; syncs wait behind it.
                    if (bus.tx_ready) begin
                        tx_data_reg <= esc_second_reg;
                        state_reg   <= SEND;
                    end
                end
                default: begin
                    tx_valid_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data     = tx_data_reg;
    assign bus.tx_valid    = tx_valid_reg;
    assign fifo_level      = level_reg;
    assign overflow_count  = overflow_reg;
    assign busy            = (state_reg != IDLE) || !fifo_empty || sync_pending_reg;
endmodule

// File: doc/uart_event_queue.md
Name: uart_event_queue

Overview:
Buffers 8-bit sequencer events ({rotary_position, button_index}) and end-of-period sync requests, then serialises them into a valid/ready byte stream that feeds uart_tx directly. This keeps button events from being lost while the UART is busy or a sync marker is being sent. Sync requests take priority over queued events. Event bytes that collide with the sync or escape codes are escaped, so the host can always tell a sync marker apart from data.

Parameters:
DEPTH, 8, event FIFO depth in bytes; must be a power of 2 and at least 2
SYNC_BYTE, 8'hFF, sync marker emitted for each sync request
ESC_BYTE, 8'hFE, escape prefix byte
ESC_XOR, 8'h20, mask XORed into an escaped event byte

Ports:
clk  input  1  system clock (12 MHz)
rstn  input  1  asynchronous active-low reset
event_valid  input  1  single-cycle strobe; event_data is pushed when high
event_data  input  8  event byte
sync_req  input  1  single-cycle strobe requesting a sync marker
tx_data  output  8  byte offered to uart_tx
tx_valid  output  1  tx_data is valid
tx_ready  input  1  uart_tx can accept a byte
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
overflow_count  output  8  number of dropped events, saturating
busy  output  1  high when the FSM is not IDLE, the FIFO is non-empty, or a sync is pending

Behaviour:
- Reset (rstn=0, asynchronous): tx_data=0, tx_valid=0, fifo_level=0, overflow_count=0, busy=0, sync_pending=0, FSM=IDLE, FIFO pointers=0. Asserting reset mid-transfer discards the byte on offer and all queued data.
- Transfer: a byte is accepted on any rising edge where tx_valid && tx_ready. While tx_valid=1, tx_data must stay stable until that byte is accepted.
- Push: event_valid=1 with fifo_level<DEPTH writes event_data at the edge. Fullness is judged on fifo_level before that edge, so a push in the same cycle as a pop when full is still dropped.
- Drop: event_valid=1 with fifo_level==DEPTH leaves the FIFO unchanged and increments overflow_count, which saturates at 255.
- Sync: sync_req=1 sets sync_pending. Extra requests while sync_pending=1 coalesce into a single marker. sync_pending clears on the edge where the FSM loads SYNC_BYTE.
- FSM states: IDLE, SEND, SEND_ESC.
  - IDLE, sync_pending=1: load tx_data=SYNC_BYTE, tx_valid=1, go to SEND. A waiting FIFO byte stays queued.
  - IDLE, sync_pending=0, FIFO non-empty: pop the head byte b.
    - If b==SYNC_BYTE or b==ESC_BYTE: load tx_data=ESC_BYTE, store b^ESC_XOR as the second byte, go to SEND_ESC.
    - Otherwise: load tx_data=b, go to SEND.
  - IDLE, nothing pending and FIFO empty: stay in IDLE with tx_valid=0.
  - SEND: on accept, tx_valid=0 and return to IDLE. This leaves one bubble cycle between bytes.
  - SEND_ESC: on accept, load the stored second byte with tx_valid=1 and go to SEND. A sync request can never fall between the two bytes of an escape pair; it waits until the pair is complete.
- Latency, starting idle with an empty FIFO:
  - event_valid sampled at edge N gives tx_valid=1 after edge N+1.
  - sync_req sampled at edge N gives tx_valid=1 after edge N+1.
- Simultaneous sync_req and event_valid: both are captured, and the sync marker is sent first.
- fifo_level: counts up by 1 on a push only, down by 1 on a pop only, and is unchanged when a push and pop happen together.
- Pointers wrap modulo DEPTH.

Test Plan:
- Idle; push 8'h3A at edge N; tx_ready=1 → tx_valid=1 after edge N+1 with tx_data=8'h3A; after the accept, tx_valid=0 and busy=0.
- Push 8'hFF, then 8'hFE, tx_ready=1 → output stream is FE DF FE DE; no unescaped FF appears.
- tx_ready=0; push 10 distinct events (one is loaded into tx_data immediately) → fifo_level=8, overflow_count=1; release tx_ready → the 9 retained bytes come out in order and the 10th is missing.
- tx_ready=0 with 3 events queued; sync_req pulsed 3 times → exactly one FF is sent, immediately after the byte currently on offer, followed by the 2 remaining events in order.
- Escape pair: assert sync_req while ESC_BYTE is on offer → order is FE, (b^20), FF.
- Assert rstn=0 mid-SEND with 4 bytes queued → tx_valid=0 and fifo_level=0 immediately; after release, nothing is emitted until a new push.
